// File: rtl/pmm_dispatcher_if.sv
// Host-stream and PMM-side signal bundle for pmm_dispatcher.
// The slave modport is the dispatcher's view. The master modport is the host/PMM side.
interface pmm_dispatcher_if #(
  parameter int NO_MODULES = 4,
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_chan;
  logic [DATA_W-1:0]            in_data;
  logic [CTRL_W-1:0]            in_control;
  logic [NO_MODULES*DATA_W-1:0] pmm_data;
  logic [NO_MODULES*CTRL_W-1:0] pmm_control;
  logic [NO_MODULES-1:0]        pmm_data_valid;
  logic [NO_MODULES-1:0]        pmm_ready_status;
  logic [NO_MODULES-1:0]        pmm_accepted_status;
  logic [NO_MODULES-1:0]        match_flags;
  logic [NO_MODULES-1:0]        clear_match;
  logic                         proto_err;
  logic                         busy;

  modport slave (
    input  in_valid, in_chan, in_data, in_control,
    input  pmm_ready_status, pmm_accepted_status, clear_match,
    output in_ready, pmm_data, pmm_control, pmm_data_valid,
    output match_flags, proto_err, busy
  );

  modport master (
    output in_valid, in_chan, in_data, in_control,
    output pmm_ready_status, pmm_accepted_status, clear_match,
    input  in_ready, pmm_data, pmm_control, pmm_data_valid,
    input  match_flags, proto_err, busy
  );
endinterface

// File: rtl/pmm_dispatcher.sv
// Splits one tagged host stream into per-channel FIFOs.
// Each channel drives its PMM through a four-phase valid/ready handshake.
//   state      | meaning
//   ST_IDLE    | output register free, waiting for a FIFO word
//   ST_ASSERT  | word presented, valid high, waiting for ready=1
//   ST_RELEASE | valid dropped, waiting for ready=0 before the next word
module pmm_dispatcher #(
  parameter int NO_MODULES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pmm_dispatcher_if.slave    bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = DATA_W + CTRL_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  logic [WORD_W-1:0]     mem_q      [NO_MODULES][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q   [NO_MODULES];
  logic [PTR_W-1:0]      rd_ptr_q   [NO_MODULES];
  logic [CNT_W-1:0]      count_q    [NO_MODULES];
  logic [CNT_W-1:0]      count_d    [NO_MODULES];
  state_t                state_q    [NO_MODULES];
  state_t                state_d    [NO_MODULES];
  logic [DATA_W-1:0]     data_q     [NO_MODULES];
  logic [DATA_W-1:0]     data_d     [NO_MODULES];
  logic [CTRL_W-1:0]     ctrl_q     [NO_MODULES];
  logic [CTRL_W-1:0]     ctrl_d     [NO_MODULES];
  logic [NO_MODULES-1:0] valid_q, valid_d;
  logic [NO_MODULES-1:0] push, pop, full, empty;
  logic [NO_MODULES-1:0] acc_sync_q, acc_prev_q;
  logic [NO_MODULES-1:0] match_q, match_d;
  logic                  proto_err_q, proto_err_d;
  logic                  chan_ok, idle_ready_err;

  // FIFO status and input acceptance; fullness is taken before any same-cycle pop
  always_comb begin
    full         = '0;
    empty        = '0;
    push         = '0;
    chan_ok      = 1'b0;
    bus.in_ready = 1'b1;
    for (int i = 0; i < NO_MODULES; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
      if (bus.in_chan == 2'(i)) begin
        chan_ok      = 1'b1;
        bus.in_ready = ~full[i];
        push[i]      = bus.in_valid & ~full[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    data_d         = data_q;
    ctrl_d         = ctrl_q;
    pop            = '0;
    idle_ready_err = 1'b0;
    for (int i = 0; i < NO_MODULES; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (bus.pmm_ready_status[i]) idle_ready_err = 1'b1;
          if (!empty[i]) begin
            pop[i]                 = 1'b1;
            {ctrl_d[i], data_d[i]} = mem_q[i][rd_ptr_q[i]];
            valid_d[i]             = 1'b1;
            state_d[i]             = ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (bus.pmm_ready_status[i]) begin
            valid_d[i] = 1'b0;
            state_d[i] = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.pmm_ready_status[i]) begin
            if (!empty[i]) begin
              pop[i]                 = 1'b1;
              {ctrl_d[i], data_d[i]} = mem_q[i][rd_ptr_q[i]];
              valid_d[i]             = 1'b1;
              state_d[i]             = ST_ASSERT;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
        end
        default: begin
          valid_d[i] = 1'b0;
          state_d[i] = ST_IDLE;
        end
      endcase
      count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
    // A set on the same edge as a clear wins
    match_d     = (match_q & ~bus.clear_match) | (acc_sync_q & ~acc_prev_q);
    proto_err_d = proto_err_q | idle_ready_err | (bus.in_valid & ~chan_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_MODULES; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        state_q[i]  <= ST_IDLE;
        data_q[i]   <= '0;
        ctrl_q[i]   <= '0;
      end
      valid_q     <= '0;
      acc_sync_q  <= '0;
      acc_prev_q  <= '0;
      match_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NO_MODULES; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= {bus.in_control, bus.in_data};
          wr_ptr_q[i]           <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_d[i];
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
      valid_q     <= valid_d;
      acc_sync_q  <= bus.pmm_accepted_status;
      acc_prev_q  <= acc_sync_q;
      match_q     <= match_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i < NO_MODULES; i++)
      if (!empty[i] || state_q[i] != ST_IDLE) bus.busy = 1'b1;
  end

  for (genvar g = 0; g < NO_MODULES; g++) begin : g_out
    assign bus.pmm_data[g*DATA_W +: DATA_W]    = data_q[g];
    assign bus.pmm_control[g*CTRL_W +: CTRL_W] = ctrl_q[g];
  end

  assign bus.pmm_data_valid = valid_q;
  assign bus.match_flags    = match_q;
  assign bus.proto_err      = proto_err_q;
endmodule

// File: tb/tb_pmm_dispatcher.sv
// Randomized bench for pmm_dispatcher.
// A queue-based reference model predicts every output on every cycle.
module tb_pmm_dispatcher;
  localparam int NM = 4;
  localparam int FD = 4;
  localparam int DW = 64;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pmm_dispatcher_if #(.NO_MODULES(NM), .DATA_W(DW), .CTRL_W(CW)) bus ();

  pmm_dispatcher #(.NO_MODULES(NM), .FIFO_DEPTH(FD), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, word on each PMM port, handshake phase
  logic [DW+CW-1:0] mq    [NM][$];
  logic [DW+CW-1:0] m_out [NM];
  int               m_ph  [NM];   // 0 idle, 1 valid up, 2 waiting ready low
  logic [NM-1:0]    m_flag, m_acc_s, m_acc_p;
  logic             m_perr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NM; i++) begin
      mq[i].delete();
      m_out[i] = '0;
      m_ph[i]  = 0;
    end
    m_flag  = '0;
    m_acc_s = '0;
    m_acc_p = '0;
    m_perr  = 1'b0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NM; i++) begin
      check($sformatf("valid%0d", i), bus.pmm_data_valid[i], m_ph[i] == 1);
      check($sformatf("data%0d", i), bus.pmm_data[i*DW +: DW], m_out[i][DW-1:0]);
      check($sformatf("ctrl%0d", i), bus.pmm_control[i*CW +: CW], m_out[i][DW+CW-1:DW]);
    end
    check("match_flags", bus.match_flags, m_flag);
    check("proto_err", bus.proto_err, m_perr);
  endtask

  // One clock: combinational checks, edge, model update, registered checks
  task automatic tick();
    logic          exp_rdy, exp_busy, rdy, do_push;
    logic [NM-1:0] rise;
    int            c;
    #1;
    c        = int'(bus.in_chan);
    exp_rdy  = (c < NM) ? (mq[c].size() < FD) : 1'b1;
    exp_busy = 1'b0;
    for (int i = 0; i < NM; i++)
      if (mq[i].size() != 0 || m_ph[i] != 0) exp_busy = 1'b1;
    check("in_ready", bus.in_ready, exp_rdy);
    check("busy", bus.busy, exp_busy);
    @(posedge clk);
    do_push = bus.in_valid && (c < NM) && (mq[c].size() < FD);
    if (bus.in_valid && c >= NM) m_perr = 1'b1;
    for (int i = 0; i < NM; i++) begin
      rdy = bus.pmm_ready_status[i];
      if (m_ph[i] == 0) begin
        if (rdy) m_perr = 1'b1;
        if (mq[i].size() > 0) begin
          m_out[i] = mq[i].pop_front();
          m_ph[i]  = 1;
        end
      end else if (m_ph[i] == 1) begin
        if (rdy) m_ph[i] = 2;
      end else if (!rdy) begin
        if (mq[i].size() > 0) begin
          m_out[i] = mq[i].pop_front();
          m_ph[i]  = 1;
        end else begin
          m_ph[i] = 0;
        end
      end
    end
    if (do_push) mq[c].push_back({bus.in_control, bus.in_data});
    rise    = m_acc_s & ~m_acc_p;
    m_flag  = (m_flag & ~bus.clear_match) | rise;
    m_acc_p = m_acc_s;
    m_acc_s = bus.pmm_accepted_status;
    #1;
    check_outputs();
  endtask

  // PMM behaviour: raise ready some time after valid, drop it some time after release
  task automatic set_ready(input int rpct, input bit spur, input logic [NM-1:0] hold);
    logic r;
    for (int i = 0; i < NM; i++) begin
      r = bus.pmm_ready_status[i];
      if (hold[i]) r = 1'b0;
      else if (m_ph[i] == 1) begin
        if (!r && $urandom_range(99) < rpct) r = 1'b1;
      end else if (m_ph[i] == 2) begin
        if (r && $urandom_range(99) < rpct) r = 1'b0;
      end else begin
        r = spur && ($urandom_range(39) == 0);
      end
      bus.pmm_ready_status[i] = r;
    end
  endtask

  task automatic rand_cycle(input int vpct, input int rpct, input bit spur, input int ch);
    bus.in_valid   = ($urandom_range(99) < vpct);
    bus.in_chan    = (ch < 0) ? 2'($urandom_range(NM-1)) : 2'(ch);
    bus.in_data    = {$urandom, $urandom};
    bus.in_control = 16'($urandom);
    for (int i = 0; i < NM; i++) begin
      bus.pmm_accepted_status[i] = ($urandom_range(5) == 0);
      bus.clear_match[i]         = ($urandom_range(9) == 0);
    end
    set_ready(rpct, spur, '0);
    tick();
  endtask

  task automatic idle_inputs();
    bus.in_valid            = 1'b0;
    bus.in_chan             = '0;
    bus.in_data             = '0;
    bus.in_control          = '0;
    bus.pmm_accepted_status = '0;
    bus.clear_match         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.pmm_ready_status = '0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.pmm_data_valid, '0);
    check("rst_data", bus.pmm_data, '0);
    check("rst_ctrl", bus.pmm_control, '0);
    check("rst_flags", bus.match_flags, '0);
    check("rst_perr", bus.proto_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int acc_n;
    idle_inputs();
    bus.pmm_ready_status = '0;
    model_clear();
    #2 do_reset();

    // Single word on ch0 with a one-cycle-latency PMM
    bus.in_valid   = 1'b1;
    bus.in_chan    = 2'd0;
    bus.in_data    = 64'h0123456789ABCDEF;
    bus.in_control = 16'h00A5;
    set_ready(100, 1'b0, '0);
    tick();
    check("lat_edge1", bus.pmm_data_valid[0], 1'b0);
    idle_inputs();
    set_ready(100, 1'b0, '0);
    tick();
    check("lat_edge2", bus.pmm_data_valid[0], 1'b1);
    check("lat_data", bus.pmm_data[DW-1:0], 64'h0123456789ABCDEF);
    check("lat_ctrl", bus.pmm_control[CW-1:0], 16'h00A5);
    repeat (6) begin
      set_ready(100, 1'b0, '0);
      tick();
    end
    check("single_busy", bus.busy, 1'b0);

    // Fill ch2 while its PMM stalls; exactly FIFO_DEPTH+1 words are taken
    acc_n = 0;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_chan    = 2'd2;
      bus.in_data    = {$urandom, $urandom};
      bus.in_control = 16'($urandom);
      set_ready(100, 1'b0, 4'b0100);
      #1;
      if (bus.in_ready) acc_n++;
      tick();
    end
    check("fill_count", acc_n, FD + 1);
    bus.in_chan = 2'd0;
    set_ready(100, 1'b0, 4'b0100);
    #1;
    check("other_chan_ready", bus.in_ready, 1'b1);
    tick();
    idle_inputs();
    repeat (40) begin
      set_ready(60, 1'b0, '0);
      tick();
    end

    // Back-to-back stream on ch1 with an immediate PMM, across pointer wrap
    for (int k = 0; k < 40; k++) rand_cycle(k < 20 ? 80 : 0, 100, 1'b0, 1);

    // Random traffic, no spurious ready
    for (int k = 0; k < 1500; k++) rand_cycle(50, 20 + (k % 5) * 20, 1'b0, -1);
    idle_inputs();
    repeat (40) begin
      set_ready(100, 1'b0, '0);
      tick();
    end

    // Accepted pulse on ch3 coinciding with a clear, then a clear alone
    bus.pmm_accepted_status[3] = 1'b1;
    bus.clear_match            = 4'b1111;
    tick();
    bus.pmm_accepted_status[3] = 1'b0;
    tick();
    bus.clear_match = '0;
    tick();
    check("match_set_wins", bus.match_flags[3], 1'b1);
    tick();
    bus.clear_match[3] = 1'b1;
    tick();
    bus.clear_match[3] = 1'b0;
    check("match_cleared", bus.match_flags[3], 1'b0);

    // Spurious ready on idle ch0
    bus.pmm_ready_status[0] = 1'b1;
    tick();
    check("spur_perr", bus.proto_err, 1'b1);
    check("spur_valid", bus.pmm_data_valid[0], 1'b0);
    bus.pmm_ready_status[0] = 1'b0;
    repeat (3) tick();
    check("perr_sticky", bus.proto_err, 1'b1);

    // Reset in the middle of an ASSERT on ch1 with three words queued
    for (int k = 0; k < 4; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_chan    = 2'd1;
      bus.in_data    = {$urandom, $urandom};
      bus.in_control = 16'($urandom);
      set_ready(100, 1'b0, 4'b0010);
      tick();
    end
    idle_inputs();
    check("pre_rst_valid", bus.pmm_data_valid[1], 1'b1);
    #3 do_reset();
    repeat (12) begin
      set_ready(100, 1'b0, '0);
      tick();
    end
    check("post_rst_valid", bus.pmm_data_valid, '0);

    // Random traffic with occasional spurious ready
    for (int k = 0; k < 800; k++) rand_cycle(60, 50, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
